// File: rtl/dp_ram_bwe.sv
// Simple dual-port RAM (1W/1R, single clock) with byte write enables, registered read,
// write-first forwarding and a post-reset clear sequencer. Optional macro: PIPE_OUT_EN.
module dp_ram_bwe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W/8-1:0]   i_we,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_W-1:0]     i_raddr,
  output logic [DATA_W-1:0]     o_rdata,
  output logic                  o_rvalid,
  output logic                  o_ready
);

  localparam int unsigned NBYTE = DATA_W / 8;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]   w_cnt_nxt;
  logic                w_clear;
  logic                r_ready;

  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [NBYTE-1:0]    w_mem_be;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [DATA_W-1:0]   w_mem_wdata;

  logic                w_rd_accept;
  logic [DATA_W-1:0]   w_rd_fwd;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_rvalid;

  // FSM state, clear counter and ready flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= (w_state_nxt == S_RUN);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clear     = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_clear   = 1'b1;
        w_cnt_nxt = r_cnt + ADDR_W'(1);
        if (r_cnt == ADDR_W'(DEPTH - 1)) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  // Clear sequencer owns the write port until RUN; user ports are ignored meanwhile
  always_comb begin
    w_mem_be    = '0;
    w_mem_addr  = i_waddr;
    w_mem_wdata = i_wdata;
    if (w_clear) begin
      w_mem_be    = '1;
      w_mem_addr  = r_cnt;
      w_mem_wdata = '0;
    end else if (r_state == S_RUN) begin
      w_mem_be    = i_we;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NBYTE); i++) begin
      if (w_mem_be[i]) begin
        r_mem[w_mem_addr][8*i +: 8] <= w_mem_wdata[8*i +: 8];
      end
    end
  end

  assign w_rd_accept = (r_state == S_RUN) && i_re;

  // Write-first per byte lane on a same-address collision
  always_comb begin
    w_rd_fwd = r_mem[i_raddr];
    for (int i = 0; i < int'(NBYTE); i++) begin
      if (i_we[i] && (i_waddr == i_raddr)) begin
        w_rd_fwd[8*i +: 8] = i_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_rd_accept;
      if (w_rd_accept) begin
        r_rdata <= w_rd_fwd;
      end
    end
  end

`ifdef PIPE_OUT_EN
  logic [DATA_W-1:0]   r_rdata_p;
  logic                r_rvalid_p;

  // Extra output stage; holds data between results like the first stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata_p  <= '0;
      r_rvalid_p <= 1'b0;
    end else begin
      r_rvalid_p <= r_rvalid;
      if (r_rvalid) begin
        r_rdata_p <= r_rdata;
      end
    end
  end

  assign o_rdata  = r_rdata_p;
  assign o_rvalid = r_rvalid_p;
`else
  assign o_rdata  = r_rdata;
  assign o_rvalid = r_rvalid;
`endif

  assign o_ready = r_ready;

endmodule

// File: tb/tb_dp_ram_bwe.sv
// Scoreboard bench for dp_ram_bwe (DATA_W=32, ADDR_W=4); works with or without PIPE_OUT_EN.
module tb_dp_ram_bwe;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned NBYTE  = DATA_W / 8;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NBYTE-1:0]    i_we = '0;
  logic [ADDR_W-1:0]   i_waddr = '0;
  logic [DATA_W-1:0]   i_wdata = '0;
  logic                i_re = 1'b0;
  logic [ADDR_W-1:0]   i_raddr = '0;
  logic [DATA_W-1:0]   o_rdata;
  logic                o_rvalid;
  logic                o_ready;

  int n_checks = 0;
  int n_errors = 0;
  int run_len  = 0;
  int max_run  = 0;
  logic [DATA_W-1:0] sb[$];

  dp_ram_bwe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_we     (i_we),
    .i_waddr  (i_waddr),
    .i_wdata  (i_wdata),
    .i_re     (i_re),
    .i_raddr  (i_raddr),
    .o_rdata  (o_rdata),
    .o_rvalid (o_rvalid),
    .o_ready  (o_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [NBYTE-1:0] be);
    i_we = be; i_waddr = a; i_wdata = d;
    tick();
    i_we = '0;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
    i_re = 1'b1; i_raddr = a; sb.push_back(exp);
    tick();
    i_re = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int c = 0;
    do begin
      tick();
      c++;
    end while (!o_ready && c < 100);
    chk(name, 32'(c), 32'(DEPTH));
  endtask

  task automatic drain();
    repeat (4) tick();
  endtask

  // Monitor: every rvalid cycle must match the oldest expected result
  initial begin
    logic [DATA_W-1:0] exp;
    forever begin
      @(negedge clk);
      if (o_rvalid) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++;
          $display("FAIL rvalid_unexpected: got rvalid=1 rdata=%h expected no result", o_rdata);
        end else begin
          exp = sb.pop_front();
          if (o_rdata !== exp) begin
            n_errors++;
            $display("FAIL rdata: got %h expected %h", o_rdata, exp);
          end
        end
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
    end
  end

  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    // Test 1: reset state, clear latency, all words zero
    repeat (3) tick();
    chk("reset_outputs", {o_rdata[29:0], o_rvalid, o_ready}, 32'h0);
    rst = 1'b0;
    wait_ready("ready_latency_initial");
    for (int a = 0; a < int'(DEPTH); a++) rd(ADDR_W'(a), 32'h0);
    drain();

    // Test 2: byte enables, then rdata holds while idle
    wr(4'd3, 32'hAABBCCDD, 4'hF);
    wr(4'd3, 32'h11223344, 4'b0101);
    rd(4'd3, 32'hAA22CC44);
    drain();
    chk("rdata_hold", o_rdata, 32'hAA22CC44);
    chk("rvalid_idle", 32'(o_rvalid), 32'h0);

    // Test 3: same-cycle collision is write-first per lane
    wr(4'd5, 32'h01020304, 4'hF);
    i_we = 4'b1000; i_waddr = 4'd5; i_wdata = 32'hFFFFFFFF;
    rd(4'd5, 32'hFF020304);
    i_we = '0;
    rd(4'd5, 32'hFF020304);
    drain();

    // Test 4: streaming reads, one result per cycle
    for (int k = 0; k < int'(DEPTH); k++) wr(ADDR_W'(k), 32'(k * 3), 4'hF);
    for (int k = 0; k < int'(DEPTH); k++) begin
      i_re = 1'b1; i_raddr = ADDR_W'(k); sb.push_back(32'(k * 3));
      tick();
    end
    i_re = 1'b0;
    drain();
    chk("stream_continuous", 32'(max_run), 32'(DEPTH));

    // Test 5a: reset in the middle of a read stream
    for (int k = 0; k < 8; k++) begin
      if (k == 5) begin
        rst = 1'b1; i_re = 1'b0;
        #1;
        chk("rst_run_outputs", {o_rdata[29:0], o_rvalid, o_ready}, 32'h0);
        sb.delete();
        break;
      end
      i_re = 1'b1; i_raddr = ADDR_W'(k); sb.push_back(32'(k * 3));
      tick();
    end
    repeat (2) tick();
    rst = 1'b0;

    // Test 5b: reset again during clear at cnt=7
    repeat (7) tick();
    chk("ready_low_in_clear", 32'(o_ready), 32'h0);
    rst = 1'b1;
    #1;
    chk("rst_clear_outputs", {o_rdata[29:0], o_rvalid, o_ready}, 32'h0);
    repeat (2) tick();
    rst = 1'b0;

    // Writes and reads issued during clear must have no effect
    i_we = 4'hF; i_waddr = 4'd0; i_wdata = 32'hDEADBEEF;
    i_re = 1'b1; i_raddr = 4'd0;
    wait_ready("ready_latency_after_rst");
    i_we = '0; i_re = 1'b0;
    for (int a = 0; a < int'(DEPTH); a++) rd(ADDR_W'(a), 32'h0);
    drain();

    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
